// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding and field limits.
// The up-counting clock block imports the same limits.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INPUT     = 3'd1,
    COUNTDOWN = 3'd2,
    PAUSED    = 3'd3,
    EXPIRED   = 3'd4
  } timer_state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Increment that wraps to zero after the given maximum; no carry out.
  function automatic logic [5:0] wrap_inc6(input logic [5:0] value, input logic [5:0] max);
    return (value >= max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/hms_decrement.sv
// Combinational H:M:S minus one second with borrow; a zero input stays zero.
module hms_decrement
  import timer_pkg::*;
(
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [4:0] hour_dec,
  output logic [5:0] min_dec,
  output logic [5:0] sec_dec,
  output logic       is_zero
);

  always_comb begin
    is_zero  = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0);
    hour_dec = hour;
    min_dec  = min;
    sec_dec  = sec;
    if (!is_zero) begin
      if (sec != 6'd0) begin
        sec_dec = sec - 6'd1;
      end else begin
        sec_dec = SEC_MAX;
        if (min != 6'd0) begin
          min_dec = min - 6'd1;
        end else begin
          min_dec  = MIN_MAX;
          hour_dec = hour - 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Settable H:M:S countdown timer driven by the 1 Hz tick; raises a timed alarm
// when the count reaches zero. All outputs are registered.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_HOUR    = 23,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       mode_in,
  input  logic       hour_in,
  input  logic       min_in,
  input  logic       sec_in,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       alarm
);

  localparam int CNT_W = $clog2(ALARM_TICKS + 1);

  timer_state_t state_reg, state_next;
  logic [4:0]   hour_reg, hour_next, hour_dec;
  logic [5:0]   min_reg, min_next, min_dec;
  logic [5:0]   sec_reg, sec_next, sec_dec;
  logic         alarm_reg, alarm_next;
  logic [CNT_W-1:0] alarm_cnt, alarm_cnt_next;
  logic         value_zero;
  logic         last_second;

  hms_decrement u_dec (
    .hour     (hour_reg),
    .min      (min_reg),
    .sec      (sec_reg),
    .hour_dec (hour_dec),
    .min_dec  (min_dec),
    .sec_dec  (sec_dec),
    .is_zero  (value_zero)
  );

  assign last_second = (hour_reg == 5'd0) && (min_reg == 6'd0) && (sec_reg == 6'd1);

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      state_reg <= IDLE;
      hour_reg  <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      alarm_reg <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state_reg <= state_next;
      hour_reg  <= hour_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      alarm_reg <= alarm_next;
      alarm_cnt <= alarm_cnt_next;
    end
  end

  // Leaving the timer mode wins over everything else and clears the value.
  always_comb begin
    state_next     = state_reg;
    hour_next      = hour_reg;
    min_next       = min_reg;
    sec_next       = sec_reg;
    alarm_next     = alarm_reg;
    alarm_cnt_next = alarm_cnt;

    if (state_reg != IDLE && !mode_in) begin
      state_next     = IDLE;
      hour_next      = '0;
      min_next       = '0;
      sec_next       = '0;
      alarm_next     = 1'b0;
      alarm_cnt_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          hour_next = '0;
          min_next  = '0;
          sec_next  = '0;
          if (mode_in && !start_stop) state_next = INPUT;
        end
        INPUT: begin
          if (start_stop && !value_zero) begin
            state_next = COUNTDOWN;
          end else begin
            if (hour_in) hour_next = (hour_reg >= 5'(MAX_HOUR)) ? 5'd0 : hour_reg + 5'd1;
            if (min_in)  min_next  = wrap_inc6(min_reg, MIN_MAX);
            if (sec_in)  sec_next  = wrap_inc6(sec_reg, SEC_MAX);
          end
        end
        COUNTDOWN: begin
          if (!start_stop) begin
            state_next = PAUSED;
          end else begin
            hour_next = hour_dec;
            min_next  = min_dec;
            sec_next  = sec_dec;
            if (last_second) begin
              state_next     = EXPIRED;
              alarm_next     = 1'b1;
              alarm_cnt_next = CNT_W'(ALARM_TICKS - 1);
            end
          end
        end
        PAUSED: begin
          if (start_stop) state_next = COUNTDOWN;
        end
        EXPIRED: begin
          if (alarm_cnt != '0) alarm_cnt_next = alarm_cnt - CNT_W'(1);
          else                 alarm_next     = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign hour_out = hour_reg;
  assign min_out  = min_reg;
  assign sec_out  = sec_reg;
  assign running  = (state_reg == COUNTDOWN);
  assign alarm    = alarm_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// phase, all compared against a seconds-based reference model.
module tb_countdown_timer;

  localparam int MAX_HOUR    = 23;
  localparam int ALARM_TICKS = 10;

  logic       clk_1Hz = 1'b0;
  logic       reset = 1'b1, start_stop = 1'b0, mode_in = 1'b0;
  logic       hour_in = 1'b0, min_in = 1'b0, sec_in = 1'b0;
  logic [4:0] hour_out;
  logic [5:0] min_out, sec_out;
  logic       running, alarm;

  int errors = 0;
  int checks = 0;

  typedef enum {S_IDLE, S_SET, S_RUN, S_HOLD, S_DONE} mstate_t;
  mstate_t mst = S_IDLE;
  int mh = 0, mm = 0, ms = 0, alarm_left = 0;

  countdown_timer #(.MAX_HOUR(MAX_HOUR), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk_1Hz    (clk_1Hz),
    .reset      (reset),
    .start_stop (start_stop),
    .mode_in    (mode_in),
    .hour_in    (hour_in),
    .min_in     (min_in),
    .sec_in     (sec_in),
    .hour_out   (hour_out),
    .min_out    (min_out),
    .sec_out    (sec_out),
    .running    (running),
    .alarm      (alarm)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic int totalSeconds();
    return mh * 3600 + mm * 60 + ms;
  endfunction

  task automatic clearModel();
    mst = S_IDLE; mh = 0; mm = 0; ms = 0; alarm_left = 0;
  endtask

  // Reference behaviour: the remaining time is treated as a plain seconds count.
  task automatic modelStep();
    int t;
    if (reset) clearModel();
    else if (mst != S_IDLE && !mode_in) clearModel();
    else begin
      case (mst)
        S_IDLE: if (mode_in && !start_stop) mst = S_SET;
        S_SET: begin
          if (start_stop && totalSeconds() != 0) mst = S_RUN;
          else begin
            if (hour_in) mh = (mh + 1) % (MAX_HOUR + 1);
            if (min_in)  mm = (mm + 1) % 60;
            if (sec_in)  ms = (ms + 1) % 60;
          end
        end
        S_RUN: begin
          if (!start_stop) mst = S_HOLD;
          else begin
            t  = totalSeconds() - 1;
            mh = t / 3600;
            mm = (t / 60) % 60;
            ms = t % 60;
            if (t == 0) begin
              mst = S_DONE;
              alarm_left = ALARM_TICKS;
            end
          end
        end
        S_HOLD: if (start_stop) mst = S_RUN;
        S_DONE: if (alarm_left > 0) alarm_left--;
        default: clearModel();
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".hour"},    32'(hour_out), 32'(mh));
    chk({tag, ".min"},     32'(min_out),  32'(mm));
    chk({tag, ".sec"},     32'(sec_out),  32'(ms));
    chk({tag, ".running"}, 32'(running),  32'(mst == S_RUN));
    chk({tag, ".alarm"},   32'(alarm),    32'(alarm_left > 0));
  endtask

  task automatic applyStimulus(input int n = 1);
    repeat (n) begin
      @(posedge clk_1Hz);
      modelStep();
      #1;
      checkOutput("model");
      hour_in = 1'b0;
      min_in  = 1'b0;
      sec_in  = 1'b0;
    end
  endtask

  task automatic pulse(input logic h, input logic m, input logic s);
    hour_in = h; min_in = m; sec_in = s;
    applyStimulus(1);
  endtask

  task automatic expectValue(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(hour_out), 32'(h));
    chk({tag, ".min"},  32'(min_out),  32'(m));
    chk({tag, ".sec"},  32'(sec_out),  32'(s));
  endtask

  task automatic expectFlags(input string tag, input logic run, input logic al);
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".alarm"},   32'(alarm),   32'(al));
  endtask

  initial begin
    applyStimulus(2);
    expectValue("reset", 0, 0, 0);
    expectFlags("reset", 1'b0, 1'b0);
    reset = 1'b0;

    mode_in = 1'b1;
    applyStimulus(1);
    repeat (5) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    expectValue("load", 0, 1, 5);
    start_stop = 1'b1;
    applyStimulus(1);
    expectValue("start", 0, 1, 5);
    expectFlags("start", 1'b1, 1'b0);
    applyStimulus(64);
    expectValue("lastsec", 0, 0, 1);
    applyStimulus(1);
    expectValue("expire", 0, 0, 0);
    expectFlags("expire", 1'b0, 1'b1);
    for (int i = 1; i < ALARM_TICKS; i++) begin
      applyStimulus(1);
      expectFlags("alarmhold", 1'b0, 1'b1);
    end
    applyStimulus(1);
    expectFlags("alarmdrop", 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    start_stop = 1'b0;
    applyStimulus(2);
    expectValue("expiredhold", 0, 0, 0);

    mode_in = 1'b0;
    applyStimulus(1);
    mode_in = 1'b1;
    applyStimulus(1);
    start_stop = 1'b1;
    applyStimulus(2);
    expectValue("zerostart", 0, 0, 0);
    expectFlags("zerostart", 1'b0, 1'b0);
    start_stop = 1'b0;
    applyStimulus(1);
    repeat (23) pulse(1'b1, 1'b0, 1'b0);
    expectValue("hour23", 23, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    expectValue("hourwrap", 0, 0, 0);
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    repeat (60) pulse(1'b0, 1'b0, 1'b1);
    expectValue("secwrap", 0, 3, 0);
    pulse(1'b1, 1'b1, 1'b1);
    expectValue("simul", 1, 4, 1);

    mode_in = 1'b0;
    applyStimulus(1);
    mode_in = 1'b1;
    applyStimulus(1);
    pulse(1'b1, 1'b0, 1'b0);
    start_stop = 1'b1;
    applyStimulus(1);
    expectValue("borrowstart", 1, 0, 0);
    applyStimulus(1);
    expectValue("borrow", 0, 59, 59);
    applyStimulus(3598);
    expectValue("borrowlast", 0, 0, 1);
    expectFlags("borrowlast", 1'b1, 1'b0);
    applyStimulus(1);
    expectFlags("borrowexpire", 1'b0, 1'b1);

    start_stop = 1'b0;
    mode_in = 1'b0;
    applyStimulus(1);
    mode_in = 1'b1;
    applyStimulus(1);
    repeat (31) pulse(1'b0, 1'b0, 1'b1);
    start_stop = 1'b1;
    applyStimulus(2);
    expectValue("at30", 0, 0, 30);
    start_stop = 1'b0;
    applyStimulus(4);
    expectValue("paused", 0, 0, 30);
    expectFlags("paused", 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    start_stop = 1'b1;
    applyStimulus(1);
    expectValue("resume", 0, 0, 30);
    expectFlags("resume", 1'b1, 1'b0);
    applyStimulus(2);
    expectValue("resumed", 0, 0, 28);

    start_stop = 1'b0;
    mode_in = 1'b0;
    applyStimulus(1);
    mode_in = 1'b1;
    applyStimulus(1);
    repeat (10) pulse(1'b0, 1'b1, 1'b0);
    start_stop = 1'b1;
    applyStimulus(1);
    expectValue("abortpre", 0, 10, 0);
    mode_in = 1'b0;
    applyStimulus(1);
    expectValue("abort", 0, 0, 0);
    expectFlags("abort", 1'b0, 1'b0);

    start_stop = 1'b0;
    mode_in = 1'b1;
    applyStimulus(1);
    repeat (5) pulse(1'b0, 1'b1, 1'b0);
    start_stop = 1'b1;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(2);
    expectValue("midreset", 0, 0, 0);
    expectFlags("midreset", 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(3);
    pulse(1'b1, 1'b1, 1'b1);
    expectValue("switchup", 0, 0, 0);
    expectFlags("switchup", 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(99) == 0);
      mode_in = ($urandom_range(39) != 0);
      if ($urandom_range(7) == 0) start_stop = ~start_stop;
      if (!start_stop) begin
        hour_in = ($urandom_range(19) == 0);
        min_in  = ($urandom_range(5) == 0);
        sec_in  = ($urandom_range(2) == 0);
      end
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
